// File: rtl/fp10_int_encoder.sv
// Converts a 16-bit unsigned integer to FP10 {exp[3:0], frac[5:0]} by shifting left one bit per cycle until normalised.
// Latency is 16-p cycles for leading one at bit p (zero: 0 extra). The result is held in DONE until out_ready.
module fp10_int_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_fp,
  output logic        out_zero,
  output logic        out_inexact
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NORM,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] sh_q, sh_d;
  logic [3:0]  e_q, e_d;
  logic [9:0]  fp_q, fp_d;
  logic        zero_q, zero_d;
  logic        inexact_q, inexact_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      e_q       <= '0;
      fp_q      <= '0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      e_q       <= e_d;
      fp_q      <= fp_d;
      zero_q    <= zero_d;
      inexact_q <= inexact_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    e_d       = e_q;
    fp_d      = fp_q;
    zero_d    = zero_q;
    inexact_d = inexact_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_data == 16'd0) begin
            fp_d      = '0;
            zero_d    = 1'b1;
            inexact_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            sh_d    = in_data;
            e_d     = 4'd15;
            state_d = S_NORM;
          end
        end
      end
      S_NORM: begin
        // A nonzero value reaches bit 15 within 15 shifts, so e never wraps.
        if (sh_q[15]) begin
          fp_d      = {e_q, sh_q[14:9]};
          inexact_d = |sh_q[8:0];
          zero_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          sh_d = {sh_q[14:0], 1'b0};
          e_d  = e_q - 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign out_fp      = fp_q;
  assign out_zero    = zero_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp10_int_encoder.sv
// Directed bench for fp10_int_encoder: encodings, latency, backpressure and asynchronous reset.
module tb_fp10_int_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_fp;
  logic        out_zero;
  logic        out_inexact;

  int checks;
  int failures;

  fp10_int_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_fp     (out_fp),
    .out_zero   (out_zero),
    .out_inexact(out_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepts d, measures edges after the accept edge until out_valid, then checks the result.
  // With release_now set, completes the handoff and checks the bubble state.
  task automatic run_conversion(input string name, input logic [15:0] d, input logic [9:0] exp_fp,
                                input logic exp_zero, input logic exp_inex, input int exp_lat,
                                input bit release_now);
    int n;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before: in_ready=%b required 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
    n = 0;
    while (out_valid !== 1'b1 && n < 24) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency: got %0d edges required %0d", name, n, exp_lat);
    end
    checks++;
    if (out_fp !== exp_fp) begin
      failures++;
      $display("FAIL %s_fp: out_fp=%b required %b", name, out_fp, exp_fp);
    end
    checks++;
    if (out_zero !== exp_zero || out_inexact !== exp_inex) begin
      failures++;
      $display("FAIL %s_flags: zero=%b inexact=%b required zero=%b inexact=%b",
               name, out_zero, out_inexact, exp_zero, exp_inex);
    end
    if (release_now) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s_handoff: out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fp !== 10'd0 ||
        out_zero !== 1'b0 || out_inexact !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_fp=%h zero=%b inexact=%b required 1 0 000 0 0",
               in_ready, out_valid, out_fp, out_zero, out_inexact);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_max_latency;
    run_conversion("one", 16'd1, 10'b0000_000000, 1'b0, 1'b0, 16, 1'b1);
  endtask

  task automatic test_min_latency;
    run_conversion("max", 16'hFFFF, 10'b1111_111111, 1'b0, 1'b1, 1, 1'b1);
  endtask

  task automatic test_exact;
    run_conversion("d100", 16'd100, 10'b0110_100100, 1'b0, 1'b0, 10, 1'b1);
    run_conversion("d1000", 16'd1000, 10'b1001_111101, 1'b0, 1'b0, 7, 1'b1);
    run_conversion("d64", 16'd64, 10'b0110_000000, 1'b0, 1'b0, 10, 1'b1);
  endtask

  task automatic test_zero_inexact;
    run_conversion("zero", 16'd0, 10'd0, 1'b1, 1'b0, 0, 1'b1);
    run_conversion("d385", 16'h0181, 10'b1000_100000, 1'b0, 1'b1, 8, 1'b1);
    run_conversion("d3", 16'd3, 10'b0001_100000, 1'b0, 1'b0, 15, 1'b1);
  endtask

  task automatic test_backpressure;
    run_conversion("bp", 16'd1000, 10'b1001_111101, 1'b0, 1'b0, 7, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 16'd7;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_fp !== 10'b1001_111101) begin
        failures++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b out_fp=%b required 1 0 1001111101",
                 i, out_valid, in_ready, out_fp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_conversion("bp_next", 16'h0181, 10'b1000_100000, 1'b0, 1'b1, 8, 1'b1);
  endtask

  task automatic test_reset_mid;
    bit seen;
    in_valid = 1'b1;
    in_data  = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fp !== 10'd0 ||
        out_zero !== 1'b0 || out_inexact !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async: in_ready=%b out_valid=%b out_fp=%h zero=%b inexact=%b required 1 0 000 0 0",
               in_ready, out_valid, out_fp, out_zero, out_inexact);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_no_result: out_valid seen=%b required 0", seen);
    end
    run_conversion("post_reset", 16'd100, 10'b0110_100100, 1'b0, 1'b0, 10, 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_max_latency();
    test_min_latency();
    test_exact();
    test_zero_inexact();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
